// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar position encoder and its echo timers.
package sonar_pkg;
  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] LED_BLANK = 5'd8;

  typedef enum logic [3:0] {
    S_IDLE, S_TRIG_X, S_RISE_X, S_MEAS_X, S_TRIG_Y, S_RISE_Y, S_MEAS_Y, S_PUBLISH, S_WAIT
  } state_e;

  typedef enum logic [1:0] {TP_IDLE, TP_LOW, TP_RISE, TP_MEAS} timer_phase_e;
endpackage

// File: rtl/echo_timer.sv
// One sensor axis: echo synchroniser, rise wait with timeout, and divider-free distance binning.
module echo_timer
  import sonar_pkg::*;
#(
  parameter int BIN_CYCLES   = 14500,
  parameter int NBINS        = 8,
  parameter int RISE_TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             echo,
  input  logic             arm,
  output logic             meas,
  output logic             done,
  output logic             valid,
  output logic [IDX_W-1:0] bin
);
  localparam int TW = $clog2(RISE_TIMEOUT + 1);
  localparam int SW = $clog2(BIN_CYCLES + 1);
  localparam int BW = $clog2(NBINS + 1);

  timer_phase_e  phase, phase_n;
  logic [1:0]    sync;
  logic          echo_s;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] sub;
  logic [BW-1:0] bcnt;
  logic          fin, fin_valid, rise, wrap;

  assign echo_s = sync[1];
  assign meas   = (phase == TP_MEAS);

  // A leftover high echo is not a rise: TP_LOW must see it drop before TP_RISE arms.
  always_comb begin
    phase_n   = phase;
    fin       = 1'b0;
    fin_valid = 1'b0;
    rise      = 1'b0;
    wrap      = 1'b0;
    case (phase)
      TP_IDLE: if (arm) phase_n = TP_LOW;
      TP_LOW, TP_RISE: begin
        if (phase == TP_RISE && echo_s) begin
          rise    = 1'b1;
          phase_n = TP_MEAS;
        end else if (tcnt == TW'(RISE_TIMEOUT - 1)) begin
          fin     = 1'b1;
          phase_n = TP_IDLE;
        end else if (phase == TP_LOW && !echo_s) begin
          phase_n = TP_RISE;
        end
      end
      TP_MEAS: begin
        if (!echo_s) begin
          fin       = 1'b1;
          fin_valid = 1'b1;
          phase_n   = TP_IDLE;
        end else if (sub == SW'(BIN_CYCLES - 1)) begin
          wrap = 1'b1;
          if (bcnt == BW'(NBINS - 1)) begin
            fin     = 1'b1;
            phase_n = TP_IDLE;
          end
        end
      end
      default: phase_n = TP_IDLE;
    endcase
  end

  // The rise cycle itself counts as the first high cycle, so width W lands in bin W/BIN_CYCLES.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      phase <= TP_IDLE;
      tcnt  <= '0;
      sub   <= '0;
      bcnt  <= '0;
      done  <= 1'b0;
      valid <= 1'b0;
      bin   <= '0;
    end else begin
      sync  <= {sync[0], echo};
      phase <= phase_n;
      done  <= fin;
      if (fin) begin
        valid <= fin_valid;
        bin   <= IDX_W'(bcnt);
      end
      tcnt <= (phase == TP_LOW || phase == TP_RISE) ? tcnt + 1'b1 : '0;
      if (rise) begin
        sub  <= SW'(1);
        bcnt <= '0;
      end else if (wrap) begin
        sub  <= '0;
        bcnt <= bcnt + 1'b1;
      end else if (phase == TP_MEAS) begin
        sub <= sub + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sonar_position_encoder.sv
// Sequences X then Y sonar pings each frame and publishes the quantised (x, y) LED cell.
module sonar_position_encoder
  import sonar_pkg::*;
#(
  parameter int TRIG_CYCLES  = 500,
  parameter int BIN_CYCLES   = 14500,
  parameter int NBINS        = 8,
  parameter int RISE_TIMEOUT = 50000,
  parameter int FRAME_CYCLES = 3000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             echo_x,
  input  logic             echo_y,
  output logic             trig_x,
  output logic             trig_y,
  output logic [IDX_W-1:0] led_x,
  output logic [IDX_W-1:0] led_y,
  output logic             update,
  output logic             no_target
);
  localparam int FW  = $clog2(FRAME_CYCLES + 1);
  localparam int TCW = $clog2(TRIG_CYCLES + 1);

  state_e           state, next;
  logic [FW-1:0]    frame_cnt;
  logic [TCW-1:0]   trig_cnt;
  logic             trig_last, frame_last, both_valid;
  logic             meas_x, meas_y, done_x, done_y, valid_x, valid_y;
  logic [IDX_W-1:0] bin_x, bin_y;

  assign trig_last  = (trig_cnt == TCW'(TRIG_CYCLES - 1));
  assign frame_last = (frame_cnt == FW'(FRAME_CYCLES - 1));
  assign both_valid = valid_x && valid_y;

  echo_timer #(.BIN_CYCLES(BIN_CYCLES), .NBINS(NBINS), .RISE_TIMEOUT(RISE_TIMEOUT)) u_timer_x (
    .clk(clk), .reset(reset), .echo(echo_x), .arm(state == S_TRIG_X && trig_last),
    .meas(meas_x), .done(done_x), .valid(valid_x), .bin(bin_x)
  );

  echo_timer #(.BIN_CYCLES(BIN_CYCLES), .NBINS(NBINS), .RISE_TIMEOUT(RISE_TIMEOUT)) u_timer_y (
    .clk(clk), .reset(reset), .echo(echo_y), .arm(state == S_TRIG_Y && trig_last),
    .meas(meas_y), .done(done_y), .valid(valid_y), .bin(bin_y)
  );

  always_comb begin
    next = state;
    case (state)
      S_IDLE:    next = S_TRIG_X;
      S_TRIG_X:  if (trig_last) next = S_RISE_X;
      S_RISE_X:  if (done_x) next = S_TRIG_Y; else if (meas_x) next = S_MEAS_X;
      S_MEAS_X:  if (done_x) next = S_TRIG_Y;
      S_TRIG_Y:  if (trig_last) next = S_RISE_Y;
      S_RISE_Y:  if (done_y) next = S_PUBLISH; else if (meas_y) next = S_MEAS_Y;
      S_MEAS_Y:  if (done_y) next = S_PUBLISH;
      S_PUBLISH: next = frame_last ? S_TRIG_X : S_WAIT;
      S_WAIT:    if (frame_last) next = S_TRIG_X;
      default:   next = S_IDLE;
    endcase
  end

  // Frame counter restarts on every TRIG_X entry and saturates so an overlong frame skips WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      frame_cnt <= '0;
      trig_cnt  <= '0;
      trig_x    <= 1'b0;
      trig_y    <= 1'b0;
      led_x     <= LED_BLANK;
      led_y     <= LED_BLANK;
      update    <= 1'b0;
      no_target <= 1'b0;
    end else begin
      state <= next;
      if (next == S_TRIG_X && state != S_TRIG_X) frame_cnt <= '0;
      else if (!frame_last)                      frame_cnt <= frame_cnt + 1'b1;
      trig_cnt <= ((state == S_TRIG_X || state == S_TRIG_Y) && !trig_last) ? trig_cnt + 1'b1 : '0;
      trig_x   <= (next == S_TRIG_X);
      trig_y   <= (next == S_TRIG_Y);
      update   <= (next == S_PUBLISH);
      if (next == S_PUBLISH) begin
        no_target <= !both_valid;
        led_x     <= both_valid ? bin_x : LED_BLANK;
        led_y     <= both_valid ? bin_y : LED_BLANK;
      end
    end
  end
endmodule
